// File: rtl/shift_add_mult_pkg.sv
// Shared types and constants for the shift-add multiplier: FSM state encoding
// and the default operand width.
package shift_add_mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mult_dp.sv
// Datapath of the shift-add multiplier: multiplier/multiplicand shift registers,
// accumulator, step counter and last-step detection (SHIFT_ADD_MULT_EARLY_TERM_EN adds zero-detect exit).
module shift_add_mult_dp #(
    parameter int WIDTH = shift_add_mult_pkg::DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 last_step
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mplier_r;
    logic [PW-1:0]    mcand_r;
    logic [PW-1:0]    acc_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] mplier_shift_s;
    logic [PW-1:0]    addend_s;
    logic             count_last_s;

    // Operand load on accept, one shift-add step per CALC cycle.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            mplier_r <= {WIDTH{1'b0}};
            mcand_r  <= {PW{1'b0}};
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (start) begin
            mplier_r <= a;
            mcand_r  <= {{WIDTH{1'b0}}, b};
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (step) begin
            mplier_r <= mplier_shift_s;
            mcand_r  <= {mcand_r[PW-2:0], 1'b0};
            acc_r    <= acc_next;
            cnt_r    <= cnt_r + CW'(1);
        end
    end

    // Next accumulator value and exit condition for the current step.
    always_comb begin
        addend_s       = mplier_r[0] ? mcand_r : {PW{1'b0}};
        acc_next       = acc_r + addend_s;
        mplier_shift_s = {1'b0, mplier_r[WIDTH-1:1]};
        count_last_s   = (cnt_r == CW'(WIDTH - 1));
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        // Once no set multiplier bits remain, further steps cannot change the sum.
        last_step      = count_last_s || (mplier_shift_s == {WIDTH{1'b0}});
`else
        last_step      = count_last_s;
`endif
    end

endmodule

// File: rtl/shift_add_mult_param.sv
// Sequential shift-add unsigned multiplier with valid/ready handshakes on both sides.
// Optional macro SHIFT_ADD_MULT_EARLY_TERM_EN shortens CALC once the multiplier runs out of ones.
module shift_add_mult_param #(
    parameter int WIDTH = shift_add_mult_pkg::DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    import shift_add_mult_pkg::*;

    state_t             state_r;
    state_t             state_s;
    logic               start_s;
    logic               step_s;
    logic               finish_s;
    logic               last_step_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [2*WIDTH-1:0] product_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    shift_add_mult_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start_s),
        .step     (step_s),
        .a        (a),
        .b        (b),
        .acc_next (acc_next_s),
        .last_step(last_step_s)
    );

    // Next-state and datapath control decode.
    always_comb begin
        state_s  = state_r;
        start_s  = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    start_s = 1'b1;
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                step_s = 1'b1;
                if (last_step_s) begin
                    finish_s = 1'b1;
                    state_s  = DONE;
                end else begin
                    state_s  = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            product_r   <= {(2*WIDTH){1'b0}};
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
            if (finish_s) begin
                product_r <= acc_next_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign product   = product_r;

endmodule

// File: tb/tb_shift_add_mult_param.sv
// Directed self-checking bench for shift_add_mult_param at WIDTH=8 and WIDTH=4;
// expected latencies follow SHIFT_ADD_MULT_EARLY_TERM_EN when the macro is defined.
module tb_shift_add_mult_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  product4;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] prev_p8;

    shift_add_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .product(product8), .busy(busy8)
    );

    shift_add_mult_param #(.WIDTH(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .product(product4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int exp_lat(input int av, input int w);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        int m;
        m = -1;
        for (int i = 0; i < w; i++) begin
            if (av[i]) m = i;
        end
        if (m < 0) return 2;
        return m + 2;
`else
        return w + 1;
`endif
    endfunction

    // Called at a negedge with dut8 idle; returns at a negedge with dut8 idle again.
    task automatic run8(input logic [7:0] oa, input logic [7:0] ob, input logic [15:0] want,
                        input int hold);
        int lat;
        check("idle_in_ready8", in_ready8, 1);
        a8 = oa; b8 = ob; in_valid8 = 1'b1;
        @(negedge clk);
        lat = 1;
        check("calc_busy8", busy8, 1);
        check("calc_in_ready8", in_ready8, 0);
        check("calc_product_hold8", product8, prev_p8);
        a8 = ~oa; b8 = ~ob; out_ready8 = 1'b1;
        while (!out_valid8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        in_valid8 = 1'b0;
        out_ready8 = (hold == 0);
        check("latency8", lat, exp_lat(int'(oa), 8));
        check("product8", product8, want);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_out_valid8", out_valid8, 1);
            check("hold_product8", product8, want);
            check("hold_in_ready8", in_ready8, 0);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check("back_idle_out_valid8", out_valid8, 0);
        check("back_idle_in_ready8", in_ready8, 1);
        check("back_idle_busy8", busy8, 0);
        check("back_idle_product8", product8, want);
        prev_p8 = want;
    endtask

    task automatic run4(input logic [3:0] oa, input logic [3:0] ob);
        int lat;
        a4 = oa; b4 = ob; in_valid4 = 1'b1;
        @(negedge clk);
        lat = 1;
        in_valid4 = 1'b0;
        while (!out_valid4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency4", lat, exp_lat(int'(oa), 4));
        check("product4", product4, int'(oa) * int'(ob));
        @(negedge clk);
    endtask

    initial begin
        logic seen_valid;
        n_rst = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = 4'd0; b4 = 4'd0;
        prev_p8 = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready8", in_ready8, 1);
        check("rst_out_valid8", out_valid8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_product8", product8, 0);
        check("rst_in_ready4", in_ready4, 1);
        check("rst_product4", product4, 0);
        n_rst = 1'b1;
        @(negedge clk);

        run8(8'd255, 8'd255, 16'hFE01, 0);
        run8(8'd0,   8'd77,  16'd0,    0);
        run8(8'd77,  8'd0,   16'd0,    0);
        run8(8'd13,  8'd11,  16'd143,  5);

        // Reset during the 4th CALC cycle discards the operation.
        a8 = 8'd200; b8 = 8'd3; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy8", busy8, 1);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        check("mid_rst_busy8", busy8, 0);
        check("mid_rst_in_ready8", in_ready8, 1);
        check("mid_rst_out_valid8", out_valid8, 0);
        check("mid_rst_product8", product8, 0);
        prev_p8 = 16'd0;
        seen_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid8) seen_valid = 1'b1;
        end
        check("mid_rst_no_out_valid8", seen_valid, 0);

        run8(8'd6,   8'd7,   16'd42,   0);
        run8(8'd1,   8'd200, 16'd200,  0);
        run8(8'd128, 8'd2,   16'd256,  0);
        run8(8'd170, 8'd85,  16'd14450, 2);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run4(4'(i), 4'(j));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
